// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ writeback
// sources, with a single registered write stage and a saturating contention counter.
module regfile_wr_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             hold,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             wr_en,
    output logic [ADDR_WIDTH-1:0]            wr_addr,
    output logic [DATA_WIDTH-1:0]            wr_data,
    output logic [CNT_WIDTH-1:0]             contend_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_WIDTH-1:0] XZR = ADDR_WIDTH'(31);

    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    logic [PTR_W-1:0]      rr_ptr_reg;
    logic [PTR_W-1:0]      rr_ptr_next;
    logic [PTR_W-1:0]      grant_idx;
    logic [PTR_W:0]        cand;
    logic [NUM_REQ-1:0]    grant;
    logic                  transfer;
    logic                  contend;
    logic                  wr_en_reg;
    logic [ADDR_WIDTH-1:0] wr_addr_reg;
    logic [DATA_WIDTH-1:0] wr_data_reg;
    logic [CNT_WIDTH-1:0]  cnt_reg;

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_reg} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!hold && !(|grant) && req_valid[cand[PTR_W-1:0]]) begin
                grant[cand[PTR_W-1:0]] = 1'b1;
                grant_idx              = cand[PTR_W-1:0];
            end
        end
    end

    assign transfer    = |grant;
    assign req_ready   = reset ? '0 : grant;
    assign rr_ptr_next = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    // More than one bit set in req_valid.
    assign contend     = (req_valid & (req_valid - 1'b1)) != '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_reg  <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            cnt_reg     <= '0;
        end else begin
            // XZR transfers are consumed and staged, but never enabled.
            wr_en_reg <= transfer && (addr_arr[grant_idx] != XZR);
            if (transfer) begin
                rr_ptr_reg  <= rr_ptr_next;
                wr_addr_reg <= addr_arr[grant_idx];
                wr_data_reg <= data_arr[grant_idx];
            end
            if (contend && !hold && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign wr_en       = wr_en_reg;
    assign wr_addr     = wr_addr_reg;
    assign wr_data     = wr_data_reg;
    assign contend_cnt = cnt_reg;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: a vector table for grant/write/hold behaviour
// plus hand-written reset-mid-write and counter saturation sequences.
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;
    logic [1:0]  req_valid;
    logic [4:0]  a0, a1;
    logic [63:0] d0, d1;
    logic [1:0]  req_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [3:0]  contend_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(
        .NUM_REQ    (2),
        .ADDR_WIDTH (5),
        .DATA_WIDTH (64),
        .CNT_WIDTH  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hold        (hold),
        .req_valid   (req_valid),
        .req_addr    ({a1, a0}),
        .req_data    ({d1, d0}),
        .req_ready   (req_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .contend_cnt (contend_cnt)
    );

    typedef struct {
        logic        hold;
        logic [1:0]  valid;
        logic [4:0]  a0;
        logic [63:0] d0;
        logic [4:0]  a1;
        logic [63:0] d1;
        logic [1:0]  ready;
        logic        en;
        logic [4:0]  waddr;
        logic [63:0] wdata;
        logic [3:0]  cnt;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic vec_t mk(logic h, logic [1:0] v, logic [4:0] x0, logic [63:0] y0,
                                logic [4:0] x1, logic [63:0] y1, logic [1:0] r, logic e,
                                logic [4:0] wa, logic [63:0] wd, logic [3:0] c);
        vec_t t;
        t.hold = h; t.valid = v; t.a0 = x0; t.d0 = y0; t.a1 = x1; t.d1 = y1;
        t.ready = r; t.en = e; t.waddr = wa; t.wdata = wd; t.cnt = c;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic h, input logic [1:0] v, input logic [4:0] x0,
                         input logic [63:0] y0, input logic [4:0] x1, input logic [63:0] y1);
        hold = h; req_valid = v; a0 = x0; d0 = y0; a1 = x1; d1 = y1;
    endtask

    initial begin
        // Registered outputs in each row reflect the transfer of the previous row.
        //              hold valid a0  d0        a1  d1      | ready en waddr wdata    cnt
        vecs[0]  = mk(0, 2'b00, 0,  64'h0,    0,  64'h0,    2'b00, 0, 0,  64'h0,    0);
        vecs[1]  = mk(0, 2'b11, 1,  64'h11,   2,  64'h22,   2'b01, 0, 0,  64'h0,    0);
        vecs[2]  = mk(0, 2'b11, 1,  64'h11,   2,  64'h22,   2'b10, 1, 1,  64'h11,   1);
        vecs[3]  = mk(0, 2'b11, 1,  64'h11,   2,  64'h22,   2'b01, 1, 2,  64'h22,   2);
        vecs[4]  = mk(0, 2'b11, 1,  64'h11,   2,  64'h22,   2'b10, 1, 1,  64'h11,   3);
        vecs[5]  = mk(0, 2'b01, 5,  64'hDEAD, 0,  64'h0,    2'b01, 1, 2,  64'h22,   4);
        vecs[6]  = mk(0, 2'b00, 0,  64'h0,    0,  64'h0,    2'b00, 1, 5,  64'hDEAD, 4);
        vecs[7]  = mk(0, 2'b00, 0,  64'h0,    0,  64'h0,    2'b00, 0, 5,  64'hDEAD, 4);
        vecs[8]  = mk(0, 2'b10, 0,  64'h0,    31, 64'hBAD,  2'b10, 0, 5,  64'hDEAD, 4);
        vecs[9]  = mk(0, 2'b11, 7,  64'h77,   3,  64'h33,   2'b01, 0, 31, 64'hBAD,  4);
        vecs[10] = mk(0, 2'b10, 0,  64'h0,    3,  64'h33,   2'b10, 1, 7,  64'h77,   5);
        vecs[11] = mk(0, 2'b01, 8,  64'h88,   0,  64'h0,    2'b01, 1, 3,  64'h33,   5);
        vecs[12] = mk(1, 2'b11, 9,  64'h99,   10, 64'hAA,   2'b00, 1, 8,  64'h88,   5);
        vecs[13] = mk(1, 2'b11, 9,  64'h99,   10, 64'hAA,   2'b00, 0, 8,  64'h88,   5);
        vecs[14] = mk(1, 2'b11, 9,  64'h99,   10, 64'hAA,   2'b00, 0, 8,  64'h88,   5);
        vecs[15] = mk(0, 2'b11, 9,  64'h99,   10, 64'hAA,   2'b10, 0, 8,  64'h88,   5);
        vecs[16] = mk(0, 2'b01, 9,  64'h99,   0,  64'h0,    2'b01, 1, 10, 64'hAA,   6);
        vecs[17] = mk(0, 2'b00, 0,  64'h0,    0,  64'h0,    2'b00, 1, 9,  64'h99,   6);

        reset = 1'b1;
        drive(0, 2'b00, 0, 64'h0, 0, 64'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].hold, vecs[i].valid, vecs[i].a0, vecs[i].d0, vecs[i].a1, vecs[i].d1);
            #1;
            $display("vec %0d: hold=%0b valid=%b ready=%b wr_en=%0b wr_addr=%0d wr_data=%0h cnt=%0d",
                     i, hold, req_valid, req_ready, wr_en, wr_addr, wr_data, contend_cnt);
            check($sformatf("v%0d ready", i), 64'(req_ready), 64'(vecs[i].ready));
            check($sformatf("v%0d wr_en", i), 64'(wr_en), 64'(vecs[i].en));
            check($sformatf("v%0d wr_addr", i), 64'(wr_addr), 64'(vecs[i].waddr));
            check($sformatf("v%0d wr_data", i), wr_data, vecs[i].wdata);
            check($sformatf("v%0d cnt", i), 64'(contend_cnt), 64'(vecs[i].cnt));
            @(posedge clk);
            #1;
        end

        // Reset in the middle of a staged write clears everything without a clock edge.
        drive(0, 2'b01, 4, 64'h44, 0, 64'h0);
        @(posedge clk);
        #1;
        check("midwr wr_en before", 64'(wr_en), 64'h1);
        #1 reset = 1'b1;
        #1;
        $display("reset mid-write: wr_en=%0b wr_addr=%0d wr_data=%0h cnt=%0d ready=%b",
                 wr_en, wr_addr, wr_data, contend_cnt, req_ready);
        check("rst wr_en", 64'(wr_en), 64'h0);
        check("rst wr_addr", 64'(wr_addr), 64'h0);
        check("rst wr_data", wr_data, 64'h0);
        check("rst cnt", 64'(contend_cnt), 64'h0);
        check("rst ready", 64'(req_ready), 64'h0);
        drive(0, 2'b00, 0, 64'h0, 0, 64'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Continuous contention: alternating grants, back-to-back pulses, saturation at 15.
        drive(0, 2'b11, 1, 64'h101, 2, 64'h202);
        for (int i = 0; i < 20; i++) begin
            #1;
            $display("sat %0d: ready=%b wr_en=%0b wr_addr=%0d cnt=%0d",
                     i, req_ready, wr_en, wr_addr, contend_cnt);
            check($sformatf("sat%0d ready", i), 64'(req_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
            check($sformatf("sat%0d cnt", i), 64'(contend_cnt), 64'((i < 15) ? i : 15));
            if (i > 0) begin
                check($sformatf("sat%0d wr_addr", i), 64'(wr_addr), (i % 2 == 1) ? 64'd1 : 64'd2);
                check($sformatf("sat%0d wr_en", i), 64'(wr_en), 64'h1);
            end
            @(posedge clk);
            #1;
        end
        #1;
        check("sat final cnt", 64'(contend_cnt), 64'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
